// File: rtl/spsram_ctrl.sv
// -----------------------------------------------------------------------------
// spsram_ctrl
//
// Initiator-side controller for a single-port SRAM macro with active-low
// chip enable (cen), write enable (wen) and output enable (oen).
//
// A request stream (one word per request, read or write) is turned into SRAM
// port cycles. Read data captured from the macro is buffered in a small
// response FIFO and returned in request order through a response stream.
//
// Pipeline, for a request accepted at the edge ending cycle N:
//   cycle N+1 : issue   - cen/wen/addr/data driven from registers
//   cycle N+2 : capture - (reads only) oen low, macro drives i_sram_data,
//                         word pushed into the FIFO at the end of the cycle
//   cycle N+3 : earliest o_rsp_valid for that read
//
// Handshake semantics (both streams): a transfer happens at a rising edge
// where valid and ready are both high. valid must not depend on ready.
// o_req_ready is derived from registers (plus i_rst) only, so there is no
// combinational path from i_req_valid or i_rsp_ready to o_req_ready.
//
// Admission is credit based: a request (read or write) is accepted only
// while fifo_count + inflight < RSP_DEPTH, where inflight is the number of
// reads accepted but not yet pushed. Every accepted read therefore owns a
// FIFO slot before it reaches the macro, and read data can never be dropped
// however long the response side stalls.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_we, i_req_addr, i_req_wdata
//                       request stream
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata
//                       read response stream (FIFO head)
//   o_sram_cen/wen/oen  SRAM strobes, active-low, registered
//   o_sram_addr/data    SRAM address and write data, registered
//   i_sram_data         SRAM read data, valid while oen is low
// -----------------------------------------------------------------------------
module spsram_ctrl #(
    parameter int BW_DATA   = 32,
    parameter int BW_ADDR   = 5,
    parameter int RSP_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [BW_ADDR-1:0] i_req_addr,
    input  logic [BW_DATA-1:0] i_req_wdata,

    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_rdata,

    output logic               o_sram_cen,
    output logic               o_sram_wen,
    output logic               o_sram_oen,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic [BW_DATA-1:0] o_sram_data,
    input  logic [BW_DATA-1:0] i_sram_data
);

    // FIFO pointer width and occupancy counter width (counter holds 0..DEPTH)
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic               sram_cen_q;
    logic               sram_wen_q;
    logic               sram_oen_q;
    logic [BW_ADDR-1:0] sram_addr_q;
    logic [BW_DATA-1:0] sram_data_q;

    // A read is being presented to the macro in the current cycle
    logic               issue_rd;

    logic [BW_DATA-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_count;

    // -------------------------------------------------------------------------
    // Handshake / credit
    // -------------------------------------------------------------------------
    logic               accept;
    logic               push;
    logic               pop;
    logic [1:0]         inflight;
    logic [CW:0]        credit_used;

    // Reads in flight are exactly those in the issue stage plus those in the
    // capture stage, so no separate counter is needed: both are registers.
    assign inflight    = {1'b0, issue_rd} + {1'b0, ~sram_oen_q};
    assign credit_used = {1'b0, fifo_count} + {{(CW - 1){1'b0}}, inflight};

    assign o_req_ready = ~i_rst & (credit_used < (CW + 1)'(RSP_DEPTH));
    assign accept      = i_req_valid & o_req_ready;

    // Capture stage is active exactly when oen is low
    assign push        = ~sram_oen_q;
    assign o_rsp_valid = (fifo_count != '0);
    assign pop         = o_rsp_valid & i_rsp_ready;

    // -------------------------------------------------------------------------
    // Issue stage: every SRAM output comes straight from a flop
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sram_cen_q  <= 1'b1;
            sram_wen_q  <= 1'b1;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            issue_rd    <= 1'b0;
        end else begin
            sram_cen_q <= ~accept;
            sram_wen_q <= ~(accept & i_req_we);
            issue_rd   <= accept & ~i_req_we;
            if (accept) begin
                sram_addr_q <= i_req_addr;
            end
            // Write data bus keeps its last value across reads and idles
            if (accept && i_req_we) begin
                sram_data_q <= i_req_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Capture stage: oen low for the cycle after a read is issued
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sram_oen_q <= 1'b1;
        end else begin
            sram_oen_q <= ~issue_rd;
        end
    end

    // -------------------------------------------------------------------------
    // Response FIFO
    // -------------------------------------------------------------------------
    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_sram_data;
        end
    end

    // Pointers wrap naturally because RSP_DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_rsp_rdata = fifo_mem[rd_ptr];
    assign o_sram_cen  = sram_cen_q;
    assign o_sram_wen  = sram_wen_q;
    assign o_sram_oen  = sram_oen_q;
    assign o_sram_addr = sram_addr_q;
    assign o_sram_data = sram_data_q;

endmodule
